// File: rtl/adc_sample_averager.sv
// Per-channel block averager for ADC conversion results: accumulates 2**LOG2_AVG
// samples per channel and emits a rounded, saturated mean on a valid/ready output.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_FLUSH | zeroing acc/cnt one channel per cycle, samples not accepted
//   S_RUN   | accumulating samples, no result pending
//   S_HOLD  | result held on out_*, waiting for out_ready
module adc_sample_averager #(
   parameter  int DATA_W   = 12,
   parameter  int NUM_CH   = 4,
   parameter  int LOG2_AVG = 3,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              in_valid,
   input  logic [CH_W-1:0]   in_ch,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_ch,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic              overrun
);

   localparam int SUM_W = DATA_W + LOG2_AVG;
   localparam int CNT_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;

   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'((2 ** LOG2_AVG) - 1);
   localparam logic [SUM_W:0]    RND      = (SUM_W + 1)'((2 ** LOG2_AVG) / 2);
   localparam logic [DATA_W-1:0] MAX_VAL  = {DATA_W{1'b1}};
   localparam logic [CH_W-1:0]   LAST_CH  = CH_W'(NUM_CH - 1);
   localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(NUM_CH);

   typedef enum logic [1:0] {S_FLUSH, S_RUN, S_HOLD} state_t;

   state_t            state_q, state_d;
   logic [CH_W-1:0]   ptr_q, ptr_d;
   logic [SUM_W-1:0]  acc_q [NUM_CH];
   logic [SUM_W-1:0]  acc_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [CH_W-1:0]   out_ch_q, out_ch_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              overrun_q, overrun_d;

   logic              ch_ok, strobe, accept, last;
   logic [SUM_W-1:0]  sel_acc, sum;
   logic [CNT_W-1:0]  sel_cnt;
   logic [SUM_W:0]    rnd_sum, mean_full;
   logic [DATA_W-1:0] mean;

   // Out-of-range channels are invisible: no accumulate, no overrun.
   assign ch_ok     = {1'b0, in_ch} < CH_LIMIT;
   assign strobe    = in_valid & ch_ok & ~clear;
   assign accept    = strobe & in_ready;
   assign sel_acc   = acc_q[in_ch];
   assign sel_cnt   = cnt_q[in_ch];
   assign last      = (sel_cnt == CNT_MAX);
   assign sum       = sel_acc + SUM_W'(in_data);
   assign rnd_sum   = {1'b0, sum} + RND;
   assign mean_full = rnd_sum >> LOG2_AVG;
   assign mean      = (mean_full > (SUM_W + 1)'(MAX_VAL)) ? MAX_VAL : mean_full[DATA_W-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_FLUSH;
         ptr_q      <= '0;
         out_ch_q   <= '0;
         out_data_q <= '0;
         overrun_q  <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         out_ch_q   <= out_ch_d;
         out_data_q <= out_data_d;
         overrun_q  <= overrun_d;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i] <= acc_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      out_ch_d   = out_ch_q;
      out_data_d = out_data_q;
      overrun_d  = overrun_q | (strobe & ~in_ready);
      if (clear) begin
         state_d   = S_FLUSH;
         ptr_d     = '0;
         overrun_d = 1'b0;
      end else begin
         case (state_q)
            S_FLUSH: begin
               acc_d[ptr_q] = '0;
               cnt_d[ptr_q] = '0;
               if (ptr_q == LAST_CH) begin
                  ptr_d   = '0;
                  state_d = S_RUN;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
            S_RUN, S_HOLD: begin
               if (state_q == S_HOLD && out_ready) state_d = S_RUN;
               if (accept) begin
                  if (last) begin
                     acc_d[in_ch] = '0;
                     cnt_d[in_ch] = '0;
                     out_ch_d     = in_ch;
                     out_data_d   = mean;
                     state_d      = S_HOLD;
                  end else begin
                     acc_d[in_ch] = sum;
                     cnt_d[in_ch] = sel_cnt + 1'b1;
                  end
               end
            end
            default: state_d = S_FLUSH;
         endcase
      end
   end

   // While a result is held, a sample may only enter in the cycle it drains.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_RUN:   in_ready = 1'b1;
         S_HOLD: begin
            in_ready  = out_ready;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   assign out_ch   = out_ch_q;
   assign out_data = out_data_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: a scoreboard-checked 8-sample averaging instance
// and a pass-through (LOG2_AVG=0) instance sharing the clock.
module tb_adc_sample_averager;

   localparam int DW  = 12;
   localparam int NCH = 4;
   localparam int L   = 3;
   localparam int BLK = 1 << L;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, clear, in_valid, in_ready, out_valid, out_ready, overrun;
   logic [1:0]    in_ch, out_ch;
   logic [DW-1:0] in_data, out_data;

   logic          rst_p, clear_p, in_valid_p, in_ready_p, out_valid_p, out_ready_p, overrun_p;
   logic [1:0]    in_ch_p, out_ch_p;
   logic [DW-1:0] in_data_p, out_data_p;

   adc_sample_averager #(.DATA_W(DW), .NUM_CH(NCH), .LOG2_AVG(L)) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ch(in_ch),
      .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid), .out_ch(out_ch),
      .out_data(out_data), .out_ready(out_ready), .overrun(overrun));

   adc_sample_averager #(.DATA_W(DW), .NUM_CH(NCH), .LOG2_AVG(0)) dut_p (
      .clk(clk), .reset(rst_p), .clear(clear_p), .in_valid(in_valid_p), .in_ch(in_ch_p),
      .in_data(in_data_p), .in_ready(in_ready_p), .out_valid(out_valid_p), .out_ch(out_ch_p),
      .out_data(out_data_p), .out_ready(out_ready_p), .overrun(overrun_p));

   typedef struct packed {
      logic [1:0]    ch;
      logic [DW-1:0] data;
   } res_t;

   res_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   m_acc[NCH];
   int   m_cnt[NCH];

   function automatic logic [DW-1:0] exp_mean(int s);
      int r;
      r = (s + BLK / 2) >> L;
      if (r > 4095) r = 4095;
      return r[DW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one strobe; the model only counts it when the bench expects acceptance.
   task automatic send(input int ch, input int d, input bit exp_acc);
      res_t r;
      in_valid = 1'b1;
      in_ch    = ch[1:0];
      in_data  = d[DW-1:0];
      if (exp_acc) begin
         m_acc[ch] += d;
         m_cnt[ch] += 1;
         if (m_cnt[ch] == BLK) begin
            r.ch   = ch[1:0];
            r.data = exp_mean(m_acc[ch]);
            sb.push_back(r);
            m_acc[ch] = 0;
            m_cnt[ch] = 0;
         end
      end
      tick();
      in_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         n_checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got ch=%0d data=%0d, required no result", out_ch, out_data);
         end else begin
            res_t e;
            e = sb.pop_front();
            if (out_ch !== e.ch || out_data !== e.data)
               $display("FAIL sb_result: got ch=%0d data=%0d, required ch=%0d data=%0d",
                        out_ch, out_data, e.ch, e.data);
            else n_pass++;
         end
      end
   end

   task automatic test_reset();
      reset = 1'b1; rst_p = 1'b1;
      clear = 1'b0; in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
      clear_p = 1'b0; in_valid_p = 1'b0; in_ch_p = '0; in_data_p = '0; out_ready_p = 1'b1;
      for (int i = 0; i < NCH; i++) begin m_acc[i] = 0; m_cnt[i] = 0; end
      repeat (2) tick();
      n_checks++;
      if ({out_valid, out_ch, out_data, overrun, in_ready} !== '0)
         $display("FAIL reset_outputs: got v=%b ch=%0d d=%0d ovr=%b rdy=%b, required all 0",
                  out_valid, out_ch, out_data, overrun, in_ready);
      else n_pass++;
      reset = 1'b0; rst_p = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         n_checks++;
         if (in_ready !== 1'b0) $display("FAIL flush_ready: cycle %0d got %b, required 0", i, in_ready);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || overrun !== 1'b0)
         $display("FAIL run_entry: got rdy=%b v=%b ovr=%b, required 1 0 0", in_ready, out_valid, overrun);
      else n_pass++;
   endtask

   task automatic test_single_block();
      out_ready = 1'b1;
      for (int i = 0; i < BLK; i++) begin
         if (i == BLK - 1) begin
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL early_valid: got %b, required 0", out_valid);
            else n_pass++;
         end
         send(1, 100 + i, 1'b1);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 12'd104 || out_ch !== 2'd1)
         $display("FAIL latency1: got v=%b ch=%0d d=%0d, required v=1 ch=1 d=104", out_valid, out_ch, out_data);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL drain: got out_valid=%b, required 0", out_valid);
      else n_pass++;
   endtask

   task automatic test_interleave();
      out_ready = 1'b1;
      for (int i = 0; i < BLK; i++) begin
         send(0, 4095, 1'b1);
         send(2, 0, 1'b1);
         send(3, 1, 1'b1);
      end
      repeat (3) tick();
      n_checks++;
      if (sb.size() != 0) $display("FAIL interleave_drain: got %0d pending, required 0", sb.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int i = 0; i < BLK - 1; i++) send(3, 10, 1'b1);
      for (int i = 0; i < BLK; i++) send(2, 50, 1'b1);
      send(0, 999, 1'b0);
      n_checks++;
      if (overrun !== 1'b1 || out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 12'd50)
         $display("FAIL overrun_hold: got ovr=%b v=%b ch=%0d d=%0d, required 1 1 2 50",
                  overrun, out_valid, out_ch, out_data);
      else n_pass++;
      out_ready = 1'b1;
      send(3, 10, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 12'd10)
         $display("FAIL b2b_reload: got v=%b ch=%0d d=%0d, required 1 3 10", out_valid, out_ch, out_data);
      else n_pass++;
      tick();
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL b2b_drop: got out_valid=%b, required 0", out_valid);
      else n_pass++;
      for (int i = 0; i < BLK; i++) send(0, 8, 1'b1);
      tick();
   endtask

   task automatic test_clear();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(1, 77, 1'b1);
      clear = 1'b1; in_valid = 1'b1; in_ch = 2'd1; in_data = 12'd5;
      tick();
      clear = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < NCH; i++) begin m_acc[i] = 0; m_cnt[i] = 0; end
      n_checks++;
      if (overrun !== 1'b0 || out_valid !== 1'b0)
         $display("FAIL clear_state: got ovr=%b v=%b, required 0 0", overrun, out_valid);
      else n_pass++;
      for (int i = 0; i < NCH; i++) begin
         n_checks++;
         if (in_ready !== 1'b0) $display("FAIL clear_flush: cycle %0d got %b, required 0", i, in_ready);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL clear_run: got in_ready=%b, required 1", in_ready);
      else n_pass++;
      for (int i = 0; i < BLK; i++) send(1, 200, 1'b1);
      tick();
   endtask

   task automatic test_pass_through();
      logic [DW-1:0] v;
      out_ready_p = 1'b1;
      n_checks++;
      if (in_ready_p !== 1'b1 || overrun_p !== 1'b0)
         $display("FAIL pt_ready: got rdy=%b ovr=%b, required 1 0", in_ready_p, overrun_p);
      else n_pass++;
      for (int k = 0; k < 6; k++) begin
         v = DW'($urandom_range(0, 4095));
         in_valid_p = 1'b1; in_ch_p = 2'(k % NCH); in_data_p = v;
         tick();
         n_checks++;
         if (out_valid_p !== 1'b1 || out_data_p !== v || out_ch_p !== 2'(k % NCH))
            $display("FAIL pt_sample: got v=%b ch=%0d d=%0d, required v=1 ch=%0d d=%0d",
                     out_valid_p, out_ch_p, out_data_p, k % NCH, v);
         else n_pass++;
      end
      in_valid_p = 1'b0;
      tick();
      n_checks++;
      if (out_valid_p !== 1'b0) $display("FAIL pt_drop: got out_valid=%b, required 0", out_valid_p);
      else n_pass++;
      out_ready_p = 1'b0;
      in_valid_p = 1'b1; in_ch_p = 2'd2; in_data_p = 12'd1234;
      tick();
      in_valid_p = 1'b0;
      tick();
      n_checks++;
      if (out_valid_p !== 1'b1 || out_data_p !== 12'd1234)
         $display("FAIL pt_hold: got v=%b d=%0d, required 1 1234", out_valid_p, out_data_p);
      else n_pass++;
      rst_p = 1'b1;
      #1;
      n_checks++;
      if (out_valid_p !== 1'b0 || out_data_p !== 12'd0)
         $display("FAIL pt_async_reset: got v=%b d=%0d, required 0 0", out_valid_p, out_data_p);
      else n_pass++;
      tick();
      rst_p = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_interleave();
      test_back_to_back();
      test_clear();
      test_pass_through();
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      n_checks++;
      if (sb.size() != 0) $display("FAIL final_drain: got %0d pending, required 0", sb.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
